// File: rtl/lsu.sv
// Memory-stage load/store unit: turns RV32I loads/stores into word-aligned
// req/ack bus transactions with byte enables and extends load data for writeback.
module lsu #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_read_m,
    input  logic                     mem_write_m,
    input  logic [2:0]               funct3_m,
    input  logic [ADDRESS_WIDTH-1:0] address_m,
    input  logic [DATA_WIDTH-1:0]    write_data_m,
    output logic [DATA_WIDTH-1:0]    read_data_m,
    output logic                     stall_m,
    output logic                     err_m,
    output logic                     bus_req,
    output logic                     bus_we,
    output logic [ADDRESS_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0]    bus_wdata,
    output logic [3:0]               bus_be,
    input  logic                     bus_ack,
    input  logic [DATA_WIDTH-1:0]    bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_d;

    logic                     bus_req_d, bus_we_d, err_d, stall_c;
    logic [ADDRESS_WIDTH-1:0] bus_addr_d;
    logic [DATA_WIDTH-1:0]    bus_wdata_d, read_data_d;
    logic [3:0]               bus_be_d;
    logic [1:0]               off_q, off_d;
    logic [2:0]               f3_q, f3_d;

    logic                     access, illegal;
    logic [3:0]               be_c;
    logic [DATA_WIDTH-1:0]    wdata_c, load_c;
    logic [7:0]               byte_c;
    logic [15:0]              half_c;

    // Legality of the request presented in IDLE
    always_comb begin
        access  = mem_read_m | mem_write_m;
        illegal = 1'b0;
        if (mem_read_m && mem_write_m) illegal = 1'b1;
        if (mem_write_m && !(funct3_m inside {3'b000, 3'b001, 3'b010})) illegal = 1'b1;
        if (mem_read_m && !(funct3_m inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
            illegal = 1'b1;
        if (funct3_m[1:0] == 2'b01 && address_m[0]) illegal = 1'b1;
        if (funct3_m == 3'b010 && address_m[1:0] != 2'b00) illegal = 1'b1;
    end

    // Store lane steering; loads always fetch the full word
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = write_data_m;
        if (mem_write_m) begin
            case (funct3_m[1:0])
                2'b00: begin
                    be_c    = 4'b0001 << address_m[1:0];
                    wdata_c = {4{write_data_m[7:0]}};
                end
                2'b01: begin
                    be_c    = address_m[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{write_data_m[15:0]}};
                end
                default: begin
                    be_c    = 4'b1111;
                    wdata_c = write_data_m;
                end
            endcase
        end
    end

    // Load lane extraction using the offset and size captured in IDLE
    always_comb begin
        byte_c = bus_rdata[{off_q, 3'b000} +: 8];
        half_c = bus_rdata[{off_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
            3'b100:  load_c = {24'h000000, byte_c};
            3'b001:  load_c = {{16{half_c[15]}}, half_c};
            3'b101:  load_c = {16'h0000, half_c};
            default: load_c = bus_rdata;
        endcase
    end

    always_comb begin
        state_d     = state;
        stall_c     = 1'b0;
        err_d       = 1'b0;
        bus_req_d   = bus_req;
        bus_we_d    = bus_we;
        bus_addr_d  = bus_addr;
        bus_wdata_d = bus_wdata;
        bus_be_d    = bus_be;
        read_data_d = read_data_m;
        off_d       = off_q;
        f3_d        = f3_q;
        case (state)
            IDLE: begin
                if (access) begin
                    if (illegal) begin
                        err_d       = 1'b1;
                        read_data_d = '0;
                    end else begin
                        stall_c     = 1'b1;
                        state_d     = BUS;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write_m;
                        bus_addr_d  = {address_m[ADDRESS_WIDTH-1:2], 2'b00};
                        bus_be_d    = be_c;
                        bus_wdata_d = wdata_c;
                        off_d       = address_m[1:0];
                        f3_d        = funct3_m;
                    end
                end
            end
            BUS: begin
                stall_c = 1'b1;
                if (bus_ack) begin
                    state_d     = DONE;
                    bus_req_d   = 1'b0;
                    read_data_d = bus_we ? '0 : load_c;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // Reset also masks the combinational IDLE stall
    assign stall_m = stall_c && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_be      <= 4'b0000;
            read_data_m <= '0;
            err_m       <= 1'b0;
            off_q       <= 2'b00;
            f3_q        <= 3'b000;
        end else begin
            state       <= state_d;
            bus_req     <= bus_req_d;
            bus_we      <= bus_we_d;
            bus_addr    <= bus_addr_d;
            bus_wdata   <= bus_wdata_d;
            bus_be      <= bus_be_d;
            read_data_m <= read_data_d;
            err_m       <= err_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against an arithmetic reference model
// of access legality, lane steering and load extension.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_m, mem_write_m;
    logic [2:0]  funct3_m;
    logic [31:0] address_m, write_data_m;
    logic [31:0] read_data_m;
    logic        stall_m, err_m;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_rd = 32'h0;

    lsu #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
        .funct3_m(funct3_m), .address_m(address_m), .write_data_m(write_data_m),
        .read_data_m(read_data_m), .stall_m(stall_m), .err_m(err_m),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input int f3);
        case (f3 % 4)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit legal_m(input bit rd, input bit wr, input int f3, input logic [31:0] addr);
        if (rd == wr) return 0;
        if (wr && !(f3 == 0 || f3 == 1 || f3 == 2)) return 0;
        if (rd && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 0;
        if ((addr % size_of(f3)) != 0) return 0;
        return 1;
    endfunction

    function automatic logic [3:0] exp_be(input bit wr, input int f3, input logic [31:0] addr);
        int mask;
        if (!wr) return 4'hF;
        mask = ((1 << size_of(f3)) - 1) << (addr % 4);
        return 4'(mask);
    endfunction

    function automatic logic [31:0] exp_wdata(input int f3, input logic [31:0] wd);
        case (size_of(f3))
            1:       return (wd & 32'hFF) * 32'h01010101;
            2:       return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input int f3, input logic [31:0] addr, input logic [31:0] rdata);
        int bits;
        longint unsigned v, m;
        bits = 8 * size_of(f3);
        v = 64'(rdata) >> (8 * (addr % 4));
        m = (64'd1 << bits) - 1;
        v = v & m;
        if (f3 < 4 && bits < 32 && v >= (64'd1 << (bits - 1))) v = v | ~m;
        return v[31:0];
    endfunction

    // ---------------- one access, start to finish ----------------
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdata, input int delay, input bit perturb);
        int stalls;
        bit ok;
        logic [31:0] e_addr, e_wdata, e_rd;
        logic [3:0]  e_be;
        ok      = legal_m(rd, wr, int'(f3), addr);
        e_addr  = addr & 32'hFFFF_FFFC;
        e_be    = exp_be(wr, int'(f3), addr);
        e_wdata = wr ? exp_wdata(int'(f3), wd) : 32'h0;
        e_rd    = wr ? 32'h0 : exp_load(int'(f3), addr, rdata);

        @(posedge clk); #1;
        check("idle_err", 32'(err_m), 32'h0);
        check("idle_rd_hold", read_data_m, last_rd);
        check("idle_req", 32'(bus_req), 32'h0);
        mem_read_m   = rd;
        mem_write_m  = wr;
        funct3_m     = f3;
        address_m    = addr;
        write_data_m = wd;
        bus_ack      = 1'($urandom_range(0, 1));
        bus_rdata    = $urandom;
        #1;

        if (!ok) begin
            check("bad_stall", 32'(stall_m), 32'h0);
            @(posedge clk); #1;
            check("bad_err", 32'(err_m), 32'h1);
            check("bad_req", 32'(bus_req), 32'h0);
            check("bad_rd", read_data_m, 32'h0);
            mem_read_m  = 1'b0;
            mem_write_m = 1'b0;
            bus_ack     = 1'b0;
            last_rd     = 32'h0;
            return;
        end

        check("idle_stall", 32'(stall_m), 32'h1);
        stalls = 1;
        for (int c = 0; c <= delay; c++) begin
            @(posedge clk); #1;
            check("bus_req", 32'(bus_req), 32'h1);
            check("bus_addr", bus_addr, e_addr);
            check("bus_be", 32'(bus_be), 32'(e_be));
            check("bus_we", 32'(bus_we), 32'(wr));
            if (wr) check("bus_wdata", bus_wdata, e_wdata);
            if (perturb) begin
                funct3_m     = 3'($urandom);
                address_m    = $urandom;
                write_data_m = $urandom;
            end
            bus_ack   = (c == delay);
            bus_rdata = (c == delay) ? rdata : $urandom;
            #1;
            if (stall_m) stalls++;
        end
        @(posedge clk); #1;
        mem_read_m  = 1'b0;
        mem_write_m = 1'b0;
        bus_ack     = 1'($urandom_range(0, 1));
        bus_rdata   = $urandom;
        #1;
        check("done_stall", 32'(stall_m), 32'h0);
        check("done_req", 32'(bus_req), 32'h0);
        check("done_rd", read_data_m, e_rd);
        check("stall_cycles", 32'(stalls), 32'(delay + 2));
        last_rd = e_rd;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        mem_read_m = 1'b0; mem_write_m = 1'b0; funct3_m = 3'b000;
        address_m = 32'h0; write_data_m = 32'h0;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        #1;
        check("rst_req", 32'(bus_req), 32'h0);
        check("rst_we", 32'(bus_we), 32'h0);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_wdata", bus_wdata, 32'h0);
        check("rst_be", 32'(bus_be), 32'h0);
        check("rst_rd", read_data_m, 32'h0);
        check("rst_err", 32'(err_m), 32'h0);
        check("rst_stall", 32'(stall_m), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset in the middle of a bus transaction
        @(posedge clk); #1;
        mem_read_m = 1'b1; funct3_m = 3'b010; address_m = 32'h600;
        @(posedge clk); #1;
        check("mid_req_before", 32'(bus_req), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_req_async", 32'(bus_req), 32'h0);
        check("mid_stall_async", 32'(stall_m), 32'h0);
        check("mid_addr_async", bus_addr, 32'h0);
        mem_read_m = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_ack_ignored", read_data_m, 32'h0);
        check("mid_req_after", 32'(bus_req), 32'h0);
        bus_ack = 1'b0;
        last_rd = 32'h0;

        // Directed cases
        do_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, 0);
        check("lb_value", read_data_m, 32'hFFFFFF80);
        do_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 0);
        check("lbu_value", read_data_m, 32'h00000080);
        do_access(1, 0, 3'b001, 32'h202, 32'h0, 32'h9ABC1234, 2, 1);
        check("lh_value", read_data_m, 32'hFFFF9ABC);
        do_access(0, 1, 3'b000, 32'h301, 32'hDEADBEEF, 32'h0, 1, 1);
        do_access(0, 1, 3'b001, 32'h402, 32'h0000CAFE, 32'h0, 0, 0);
        do_access(1, 0, 3'b101, 32'h402, 32'h0, 32'h8001_7FFF, 1, 0);
        check("lhu_value", read_data_m, 32'h00008001);
        do_access(1, 0, 3'b010, 32'h501, 32'h0, 32'h0, 0, 0);
        do_access(1, 0, 3'b011, 32'h500, 32'h0, 32'h0, 0, 0);
        do_access(1, 1, 3'b010, 32'h500, 32'h0, 32'h0, 0, 0);
        do_access(0, 1, 3'b100, 32'h500, 32'h0, 32'h0, 0, 0);
        do_access(0, 1, 3'b001, 32'h501, 32'h0, 32'h0, 0, 0);

        // Randomized accesses
        for (int n = 0; n < 120; n++) begin
            int r;
            bit rd, wr;
            logic [2:0]  f3;
            logic [31:0] addr;
            r  = int'($urandom_range(0, 11));
            rd = (r == 0) || (r < 6);
            wr = (r == 0) || (r >= 6);
            f3 = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) addr = addr & ~32'(size_of(int'(f3)) - 1);
            do_access(rd, wr, f3, addr, $urandom, $urandom,
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        @(posedge clk); #1;
        check("final_err", 32'(err_m), 32'h0);
        check("final_rd_hold", read_data_m, last_rd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
